// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; a single-digit configuration still keeps one bit.
    function automatic int unsigned cnt_width(input int unsigned ndig);
        return (ndig > 2) ? 32'($clog2(ndig)) : 32'd1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry slice; also exposes the carry into its top bit for overflow.
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per cycle, LSB first,
// with valid/ready handshakes on both sides.
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = cnt_width(NDIG);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CW-1:0]    cnt_q;

    logic             load_c, step_c, last_c;
    logic [DIGIT-1:0] s_c;
    logic             co_c, cmsb_c;

    assign last_c = (cnt_q == CW'(NDIG - 1));

    digit_adder #(.DIGIT(DIGIT)) u_slice (
        .x     (a_q[cnt_q*DIGIT +: DIGIT]),
        .y     (b_q[cnt_q*DIGIT +: DIGIT]),
        .ci    (carry_q),
        .s     (s_c),
        .co    (co_c),
        .c_msb (cmsb_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (last_c) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is a + ~b + ~cin, so B is stored inverted and the carry seeded with cin^sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (load_c) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
        end else if (step_c) begin
            sum_q[cnt_q*DIGIT +: DIGIT] <= s_c;
            carry_q                     <= co_c;
            if (last_c) begin
                cout_q <= co_c;
                ovf_q  <= co_c ^ cmsb_c;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
